// File: rtl/sync_fifo_pkg.sv
// ============================================================================
// Module      : sync_fifo_pkg
// Description : Shared helpers, default thresholds and status struct for sync_fifo_th.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sync_fifo_pkg;

    localparam int c_DEF_WORD_LENGTH     = 8;
    localparam int c_DEF_ADDR_BITS       = 4;
    localparam int c_ALMOST_EMPTY_THR    = 2;
    localparam int c_ALMOST_FULL_MARGIN  = 2;

    function automatic int fifo_depth(input int addr_bits);
        return 1 << addr_bits;
    endfunction

    function automatic int count_width(input int addr_bits);
        return addr_bits + 1;
    endfunction

    typedef struct packed {
        logic empty;
        logic full;
        logic almost_empty;
        logic almost_full;
        logic overflow;
        logic underflow;
    } fifo_status_t;

endpackage

`default_nettype wire

// File: rtl/sync_fifo_th_if.sv
// ============================================================================
// Module      : sync_fifo_th_if
// Description : Producer/consumer bus of sync_fifo_th (requests, data, status).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sync_fifo_th_if #(
    parameter int WordLength = 8,
    parameter int AddrBits   = 4
);
    logic                  clr_i;
    logic                  wr_i;
    logic [WordLength-1:0] w_data_i;
    logic                  rd_i;
    logic [WordLength-1:0] r_data_o;
    logic                  r_valid_o;
    logic                  empty_o;
    logic                  full_o;
    logic                  almost_empty_o;
    logic                  almost_full_o;
    logic [AddrBits:0]     count_o;
    logic                  overflow_o;
    logic                  underflow_o;

    modport master (
        output clr_i, wr_i, w_data_i, rd_i,
        input  r_data_o, r_valid_o, empty_o, full_o, almost_empty_o,
               almost_full_o, count_o, overflow_o, underflow_o
    );

    modport slave (
        input  clr_i, wr_i, w_data_i, rd_i,
        output r_data_o, r_valid_o, empty_o, full_o, almost_empty_o,
               almost_full_o, count_o, overflow_o, underflow_o
    );
endinterface

`default_nettype wire

// File: rtl/sync_fifo_ctrl.sv
// ============================================================================
// Module      : sync_fifo_ctrl
// Description : Pointers, occupancy count, accept logic and status flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo_ctrl
    import sync_fifo_pkg::*;
#(
    parameter int AddrBits       = 4,
    parameter int AlmostFullThr  = 14,
    parameter int AlmostEmptyThr = 2
) (
    input  wire logic                clk,
    input  wire logic                rst_n,
    input  wire logic                clr,
    input  wire logic                wr,
    input  wire logic                rd,
    output logic                     wr_en,
    output logic                     rd_en,
    output logic [AddrBits-1:0]      wr_addr,
    output logic [AddrBits-1:0]      rd_addr,
    output logic [AddrBits:0]        count,
    output fifo_status_t             status
);

    localparam logic [AddrBits:0] c_ONE    = {{AddrBits{1'b0}}, 1'b1};
    localparam logic [AddrBits:0] c_DEPTH  = (AddrBits+1)'(fifo_depth(AddrBits));
    localparam logic [AddrBits:0] c_AF_THR = (AddrBits+1)'(AlmostFullThr);
    localparam logic [AddrBits:0] c_AE_THR = (AddrBits+1)'(AlmostEmptyThr);

    logic [AddrBits:0] r_wr_ptr;
    logic [AddrBits:0] r_rd_ptr;
    logic [AddrBits:0] r_count;
    logic [AddrBits:0] w_count_next;
    logic              r_overflow;
    logic              r_underflow;
    logic              w_empty;
    logic              w_full;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_DEPTH);

    // A read frees a slot, so a write is still accepted at full if a read pops.
    assign rd_en = rd && !w_empty && !clr;
    assign wr_en = wr && (!w_full || rd_en) && !clr;

    always_comb begin
        w_count_next = r_count;
        if (wr_en && !rd_en) begin
            w_count_next = r_count + c_ONE;
        end else if (rd_en && !wr_en) begin
            w_count_next = r_count - c_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (clr) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (wr_en) r_wr_ptr <= r_wr_ptr + c_ONE;
            if (rd_en) r_rd_ptr <= r_rd_ptr + c_ONE;
            r_count     <= w_count_next;
            r_overflow  <= r_overflow  | (wr && w_full && !rd);
            r_underflow <= r_underflow | (rd && w_empty);
        end
    end

    assign wr_addr = r_wr_ptr[AddrBits-1:0];
    assign rd_addr = r_rd_ptr[AddrBits-1:0];
    assign count   = r_count;

    always_comb begin
        status              = '0;
        status.empty        = w_empty;
        status.full         = w_full;
        status.almost_empty = (r_count <= c_AE_THR);
        status.almost_full  = (r_count >= c_AF_THR);
        status.overflow     = r_overflow;
        status.underflow    = r_underflow;
    end

endmodule

`default_nettype wire

// File: rtl/sync_fifo_th.sv
// ============================================================================
// Module      : sync_fifo_th
// Description : Synchronous FIFO with thresholds, count, sticky errors, flush.
//               Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo_th
    import sync_fifo_pkg::*;
#(
    parameter int WordLength     = c_DEF_WORD_LENGTH,
    parameter int AddrBits       = c_DEF_ADDR_BITS,
    parameter int AlmostFullThr  = fifo_depth(AddrBits) - c_ALMOST_FULL_MARGIN,
    parameter int AlmostEmptyThr = c_ALMOST_EMPTY_THR
) (
    input  wire logic     clk_i,
    input  wire logic     rst_ni,
    sync_fifo_th_if.slave bus
);

    logic                  w_wr_en;
    logic                  w_rd_en;
    logic [AddrBits-1:0]   w_wr_addr;
    logic [AddrBits-1:0]   w_rd_addr;
    logic [AddrBits:0]     w_count;
    fifo_status_t          w_status;
    logic [WordLength-1:0] r_mem [fifo_depth(AddrBits)];

    sync_fifo_ctrl #(
        .AddrBits       (AddrBits),
        .AlmostFullThr  (AlmostFullThr),
        .AlmostEmptyThr (AlmostEmptyThr)
    ) u_ctrl (
        .clk     (clk_i),
        .rst_n   (rst_ni),
        .clr     (bus.clr_i),
        .wr      (bus.wr_i),
        .rd      (bus.rd_i),
        .wr_en   (w_wr_en),
        .rd_en   (w_rd_en),
        .wr_addr (w_wr_addr),
        .rd_addr (w_rd_addr),
        .count   (w_count),
        .status  (w_status)
    );

    always_ff @(posedge clk_i) begin
        if (w_wr_en) r_mem[w_wr_addr] <= bus.w_data_i;
    end

`ifdef SYNC_FIFO_FWFT_EN
    // Head word shown directly from the array; zero while empty.
    assign bus.r_data_o  = w_status.empty ? '0 : r_mem[w_rd_addr];
    assign bus.r_valid_o = !w_status.empty;
`else
    logic [WordLength-1:0] r_rd_data;
    logic                  r_rd_valid;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_en;
            if (w_rd_en) r_rd_data <= r_mem[w_rd_addr];
        end
    end

    assign bus.r_data_o  = r_rd_data;
    assign bus.r_valid_o = r_rd_valid;
`endif

    assign bus.count_o        = w_count;
    assign bus.empty_o        = w_status.empty;
    assign bus.full_o         = w_status.full;
    assign bus.almost_empty_o = w_status.almost_empty;
    assign bus.almost_full_o  = w_status.almost_full;
    assign bus.overflow_o     = w_status.overflow;
    assign bus.underflow_o    = w_status.underflow;

endmodule

`default_nettype wire

// File: doc/sync_fifo_th.md
# sync_fifo_th

Parametrised synchronous FIFO, the next generation of the team's `fifo` block. It adds programmable almost-full/almost-empty thresholds, an occupancy count, sticky overflow/underflow error flags, a synchronous flush, and compile-time selection of first-word-fall-through (FWFT) reads. It sits between any single-clock producer/consumer pair and is driven by the existing `fifo_if`-style benches.

## Interface
- `WordLength`, 8, data width in bits
- `AddrBits`, 4, log2 of depth; DEPTH = 2**AddrBits
- `AlmostFullThr`, DEPTH-2, `almost_full_o` asserts when count >= this value
- `AlmostEmptyThr`, 2, `almost_empty_o` asserts when count <= this value
- `clk_i` in 1 single clock; all logic on its rising edge
- `rst_ni` in 1 reset, asynchronous assert, active-low
- `clr_i` in 1 synchronous flush; empties the FIFO and clears the sticky flags
- `wr_i` in 1 write request
- `w_data_i` in WordLength write data
- `rd_i` in 1 read request
- `r_data_o` out WordLength read data
- `r_valid_o` out 1 `r_data_o` qualifier
- `empty_o` / `full_o` out 1 count == 0 / count == DEPTH
- `almost_empty_o` / `almost_full_o` out 1 threshold flags
- `count_o` out AddrBits+1 current occupancy, 0..DEPTH
- `overflow_o` / `underflow_o` out 1 sticky error flags

## Operation
- Pointers are AddrBits+1 bits wide and wrap modulo 2*DEPTH; the memory index is the low AddrBits bits. `count_o` is a register updated with the pointers; it never exceeds DEPTH.
- Read accepted = `rd_i && !empty_o`. Write accepted = `wr_i && (!full_o || read accepted)`.
- Full with `wr_i` and `rd_i` both high: both accepted, count unchanged, no overflow.
- Empty with `wr_i` and `rd_i` both high: write accepted, read rejected, `underflow_o` set.
- `wr_i` while full without a read: write dropped, memory and pointers unchanged, `overflow_o` set. `rd_i` while empty: `underflow_o` set, `r_valid_o` stays low.
- Sticky flags hold until `clr_i` or reset.
- `clr_i` has priority over `wr_i`/`rd_i` in the same cycle. It zeroes the pointers and count, clears the sticky flags and `r_valid_o`, and discards that cycle's requests.
- Flags decode combinationally from the count register.
- Memory contents are not reset.

## Timing
- Reset values: `empty_o`=1, `almost_empty_o`=1, all other outputs 0, `r_data_o`=0.
- Reset asserted mid-operation drops all contents immediately, asynchronously.
- Count and flags reflect an accepted operation in the cycle after its edge (1-cycle latency).
- Non-FWFT read latency is 1: a read accepted at edge N drives `r_data_o` from edge N, with `r_valid_o` high for that one cycle. `r_data_o` holds its last value otherwise.
- DEPTH consecutive writes from empty give `full_o`=1 after the DEPTH-th edge.

## Configuration
- `SYNC_FIFO_FWFT_EN` defined:
  - `r_data_o` continuously shows the head word while not empty; `r_valid_o` = `!empty_o`.
  - A word written into an empty FIFO is visible the cycle after its write edge.
  - `rd_i` acknowledges and pops the shown word.
- Not defined: standard mode with registered 1-cycle read latency, as in Timing.

## Structure
- `sync_fifo_pkg` holds the depth/count-width helper functions, the default threshold constants, and a `fifo_status_t` struct (empty, full, almost_empty, almost_full, overflow, underflow).
- One sub-module, `sync_fifo_ctrl`, contains the pointers, count, accept logic and flags.
- The top level holds the memory array and the read-data/FWFT output path.

## Test plan
- Reset, then write 0x01..0x10 (16 words, default params) -> `full_o`=1, `count_o`=16, `almost_full_o` from count 14. Then 16 reads -> data 0x01..0x10 in order, `empty_o`=1.
- Write while full (0xAA) -> `overflow_o`=1, count stays 16, 0xAA never read back. Then `clr_i` -> count 0, `overflow_o`=0.
- Read while empty -> `underflow_o`=1, `r_valid_o`=0, pointers unchanged.
- Simultaneous `wr_i`/`rd_i` at full, then at count 5 -> count unchanged in both cases, order preserved. At empty -> count 1, `underflow_o`=1.
- 40 writes interleaved with reads across pointer wrap -> scoreboard matches, `count_o` never exceeds 16.
- `rst_ni` low mid-burst at count 7 -> outputs return to reset values immediately. Repeat all scenarios with `SYNC_FIFO_FWFT_EN` defined -> head word visible one cycle after the first write.
